// File: rtl/key_mix_serializer_if.sv
// Handshake bundle between the expansion stage, the key mixer and the S-box stage.
// The slave side is the serializer; the master side is whatever drives it.
interface key_mix_serializer_if #(
  parameter int DATA_W  = 48,
  parameter int CHUNK_W = 6
);
  localparam int N_CHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [DATA_W-1:0]   in_key;
  logic                out_valid;
  logic                out_ready;
  logic [CHUNK_W-1:0]  out_chunk;
  logic [IDX_W-1:0]    out_idx;
  logic                out_last;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_chunk, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_chunk, out_idx, out_last
  );
endinterface

// File: rtl/key_mix_serializer.sv
// XORs an expanded half-block with its round subkey and streams the result
// MSB-first as S-box-sized chunks; a new block can load as the last chunk leaves.
module key_mix_serializer #(
  parameter int DATA_W  = 48,
  parameter int CHUNK_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  key_mix_serializer_if.slave   io_bus
);
  localparam int N_CHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNK - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_next;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   w_hold_next;
  logic [DATA_W-1:0]   w_mixed;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_at_last;

  // Per-S-box slice of the key mix; the hold register stores it MSB chunk first.
  for (genvar gi = 0; gi < N_CHUNK; gi++) begin : g_mix
    assign w_mixed[gi*CHUNK_W +: CHUNK_W] =
      io_bus.in_data[gi*CHUNK_W +: CHUNK_W] ^ io_bus.in_key[gi*CHUNK_W +: CHUNK_W];
  end

  assign w_at_last = (r_idx == LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_hold_next  = r_hold;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (io_bus.in_valid) begin
          w_hold_next  = w_mixed;
          w_idx_next   = '0;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        w_out_valid = 1'b1;
        if (io_bus.out_ready) begin
          if (w_at_last) begin
            // Last chunk leaving frees the hold register this very cycle.
            w_in_ready = 1'b1;
            if (io_bus.in_valid) begin
              w_hold_next = w_mixed;
              w_idx_next  = '0;
            end else begin
              w_hold_next  = '0;
              w_idx_next   = '0;
              w_state_next = ST_IDLE;
            end
          end else begin
            w_idx_next  = r_idx + IDX_W'(1);
            w_hold_next = {r_hold[DATA_W-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_hold  <= w_hold_next;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.out_chunk = r_hold[DATA_W-1 -: CHUNK_W];
  assign io_bus.out_idx   = r_idx;
  assign io_bus.out_last  = w_out_valid && w_at_last;
endmodule

// File: tb/tb_key_mix_serializer.sv
// Directed bench for key_mix_serializer: hand-computed chunk tables plus a
// scoreboard that expands every accepted block into its eight expected chunks.
module tb_key_mix_serializer;
  logic clk;
  logic rst_n;

  key_mix_serializer_if #(.DATA_W(48), .CHUNK_W(6)) bus ();

  key_mix_serializer #(.DATA_W(48), .CHUNK_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] chunk;
    logic [2:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] log_q[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  int         n_blocks = 0;

  task automatic check_value(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, inputs move just after rising edges.
  logic       prev_stall = 1'b0;
  logic [5:0] prev_chunk;
  logic [2:0] prev_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_value("stall_valid", bus.out_valid, 1'b1);
        check_value("stall_chunk", bus.out_chunk, prev_chunk);
        check_value("stall_idx",   bus.out_idx,   prev_idx);
      end
      check_value("in_ready_rule", bus.in_ready,
                  !bus.out_valid || (bus.out_idx == 3'd7 && bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        check_value("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_value("sb_chunk", bus.out_chunk, e.chunk);
          check_value("sb_idx",   bus.out_idx,   e.idx);
          check_value("sb_last",  bus.out_last,  e.idx == 3'd7);
        end
        log_q.push_back(bus.out_chunk);
      end
      if (bus.in_valid && bus.in_ready) begin
        logic [47:0] m;
        m = bus.in_data ^ bus.in_key;
        for (int k = 0; k < 8; k++) begin
          exp_t e;
          e.chunk = m[47-6*k -: 6];
          e.idx   = 3'(k);
          exp_q.push_back(e);
        end
        n_blocks++;
        $display("block %0d accepted: data=%012h key=%012h mixed=%012h", n_blocks, bus.in_data, bus.in_key, m);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_chunk = bus.out_chunk;
      prev_idx   = bus.out_idx;
    end
  end

  // Offers one block from a post-edge slot; returns in the slot after the accepting edge.
  task automatic send_block(input logic [47:0] d, input logic [47:0] k);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_key   = k;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    bus.in_valid = 1'b0;
    check_value("accept", acc, 1'b1);
    check_value("lat_valid", bus.out_valid, 1'b1);
    check_value("lat_idx",   bus.out_idx,   3'd0);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!bus.out_valid && exp_q.size() == 0) break;
    end
    check_value("drain_q",     exp_q.size(), 0);
    check_value("drain_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  logic [5:0] tbl_a[8]  = '{6'h04, 6'h23, 6'h11, 6'h16, 6'h1E, 6'h09, 6'h2A, 6'h3C};
  logic [5:0] tbl_st[8] = '{6'h00, 6'h12, 6'h0D, 6'h05, 6'h19, 6'h38, 6'h26, 6'h2B};

  initial begin
    int          nacc, vcnt, rcnt, blk0;
    logic        fire;
    logic [63:0] r64;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    check_value("rst_out_valid", bus.out_valid, 1'b0);
    check_value("rst_in_ready",  bus.in_ready,  1'b1);
    check_value("rst_out_chunk", bus.out_chunk, 6'h00);
    check_value("rst_out_idx",   bus.out_idx,   3'd0);
    check_value("rst_out_last",  bus.out_last,  1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // Plain data, zero key
    log_q.delete();
    send_block(48'h123456789ABC, 48'h0);
    wait_drain();
    check_value("a_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      check_value($sformatf("a_chunk%0d", i), log_q[i], tbl_a[i]);

    // Two blocks back to back with in_valid held: all-zero then all-ones chunks
    log_q.delete();
    nacc = 0; vcnt = 0; rcnt = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 48'hFFFFFFFFFFFF;
    bus.in_key   = 48'hFFFFFFFFFFFF;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (nacc == 2 && !bus.out_valid) break;
      if (bus.out_valid) vcnt++;
      if (bus.in_ready) rcnt++;
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (fire) begin
        nacc++;
        if (nacc == 1) begin
          bus.in_data = 48'h0;
          bus.in_key  = 48'hFFFFFFFFFFFF;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    check_value("b2b_accepts",   nacc, 2);
    check_value("b2b_valid_cyc", vcnt, 16);
    check_value("b2b_ready_cyc", rcnt, 3);
    check_value("b2b_count", log_q.size(), 16);
    for (int i = 0; i < 16 && i < log_q.size(); i++)
      check_value($sformatf("b2b_chunk%0d", i), log_q[i], (i < 8) ? 6'h00 : 6'h3F);

    // Downstream stall at idx 3
    log_q.delete();
    send_block(48'h0123456789AB, 48'h0);
    for (int c = 0; c < 20; c++) begin
      if (bus.out_idx == 3'd3) break;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_value("stall_hold_valid", bus.out_valid, 1'b1);
      check_value("stall_hold_chunk", bus.out_chunk, 6'h05);
      check_value("stall_hold_idx",   bus.out_idx,   3'd3);
      check_value("stall_in_ready",   bus.in_ready,  1'b0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain();
    check_value("stall_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      check_value($sformatf("stall_chunk%0d", i), log_q[i], tbl_st[i]);

    // Asynchronous reset in the middle of a block
    send_block(48'h123456789ABC, 48'hFFFFFFFFFFFF);
    for (int c = 0; c < 20; c++) begin
      if (bus.out_idx == 3'd5) break;
      @(posedge clk); #1;
    end
    check_value("pre_rst_idx", bus.out_idx, 3'd5);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_value("arst_out_valid", bus.out_valid, 1'b0);
    check_value("arst_in_ready",  bus.in_ready,  1'b1);
    check_value("arst_out_idx",   bus.out_idx,   3'd0);
    check_value("arst_out_last",  bus.out_last,  1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    log_q.delete();
    send_block(48'h0, 48'h123456789ABC);
    wait_drain();
    check_value("post_rst_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      check_value($sformatf("post_rst_chunk%0d", i), log_q[i], tbl_a[i]);

    // Random handshakes against the scoreboard
    blk0 = n_blocks;
    for (int c = 0; c < 60000 && (n_blocks - blk0) < 1000; c++) begin
      r64 = {$urandom(), $urandom()};
      bus.in_data   = r64[47:0];
      r64 = {$urandom(), $urandom()};
      bus.in_key    = r64[47:0];
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();
    check_value("rand_blocks", n_blocks - blk0, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
